// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone-style register-file responder.
// It provides DEPTH-1 R/W registers and one read-only status word at the top address.
// Each transfer completes with a single-cycle ack after WAIT_STATES extra cycles.
// Register 0 is exported as ctrl_out.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for cycle&strobe; request fields are taken from the bus
// S_WAIT | counting wait states; a dropped cycle/strobe aborts the transfer
// S_ACK  | ack high for exactly this cycle; always returns to S_IDLE
module wb_reg_slave #(
  parameter int                 ADDR_W      = 4,
  parameter int                 DATA_W      = 16,
  parameter int                 WAIT_STATES = 0,
  parameter logic [DATA_W-1:0]  RST_VAL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cycle,
  input  logic              strobe,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic              ack,
  output logic [DATA_W-1:0] rdData,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] ctrl_out
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] STAT_ADR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state, state_nxt;
  logic [3:0]        count, count_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] regs [DEPTH-1];

  logic              req;
  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] x_addr;
  logic              x_write;
  logic [DATA_W-1:0] x_wdata;
  logic [DATA_W-1:0] rd_mux;

  assign req    = cycle & strobe;
  assign accept = (state == S_IDLE) && req;
  // Entering S_ACK is the single point where a transfer takes effect.
  assign commit = (state_nxt == S_ACK);

  // With zero wait states the commit edge is also the accept edge, so the
  // transfer fields must come straight from the bus rather than the latches.
  assign x_addr  = (state == S_IDLE) ? addr   : addr_q;
  assign x_write = (state == S_IDLE) ? write  : write_q;
  assign x_wdata = (state == S_IDLE) ? wrData : wdata_q;

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            count_nxt = CNT_LOAD;
          end else begin
            state_nxt = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (!req)
          state_nxt = S_IDLE;
        else if (count == 4'd0)
          state_nxt = S_ACK;
        else
          count_nxt = count - 4'd1;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs and the read mux; the top address returns the live status word.
  always_comb begin
    ack      = (state == S_ACK);
    ctrl_out = regs[0];
    rd_mux   = status_in;
    if (x_addr != STAT_ADR)
      rd_mux = regs[x_addr];
  end

  // Request latches, register file and registered read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdData  <= '0;
      for (int i = 0; i < DEPTH - 1; i++)
        regs[i] <= RST_VAL;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        write_q <= write;
        wdata_q <= wrData;
      end
      if (commit && x_write && (x_addr != STAT_ADR))
        regs[x_addr] <= x_wdata;
      rdData <= (commit && !x_write) ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_wb_reg_slave.sv
// Testbench for wb_reg_slave: two instances (0 and 3 wait states) on one clock.
// Expected acks are queued at issue time and matched by a negedge monitor.
module tb_wb_reg_slave;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_i [2];
  logic        stb_i [2];
  logic        we_i  [2];
  logic [3:0]  adr_i [2];
  logic [15:0] wd_i  [2];
  logic        ack_o [2];
  logic [15:0] rd_o  [2];
  logic [15:0] ctrl_o[2];
  logic [15:0] status;

  exp_t        sb_q [2][$];
  exp_t        e;
  logic        prev_ack[2];
  logic        mon_en = 1'b0;
  int unsigned cyc_cnt = 0;
  int          n_tot = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_reg_slave #(.ADDR_W(4), .DATA_W(16), .WAIT_STATES(0), .RST_VAL(16'h0000)) u0 (
    .clk(clk), .rst(rst), .cycle(cyc_i[0]), .strobe(stb_i[0]), .write(we_i[0]),
    .addr(adr_i[0]), .wrData(wd_i[0]), .ack(ack_o[0]), .rdData(rd_o[0]),
    .status_in(status), .ctrl_out(ctrl_o[0]));

  wb_reg_slave #(.ADDR_W(4), .DATA_W(16), .WAIT_STATES(3), .RST_VAL(16'h0000)) u3 (
    .clk(clk), .rst(rst), .cycle(cyc_i[1]), .strobe(stb_i[1]), .write(we_i[1]),
    .addr(adr_i[1]), .wrData(wd_i[1]), .ack(ack_o[1]), .rdData(rd_o[1]),
    .status_in(status), .ctrl_out(ctrl_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // One complete transfer; bus fields are scrambled after accept to show they are ignored.
  task automatic xfer(input int d, input logic wr, input logic [3:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rd);
    exp_t x;
    @(negedge clk);
    cyc_i[d] = 1'b1; stb_i[d] = 1'b1; we_i[d] = wr; adr_i[d] = a; wd_i[d] = wd;
    x.is_rd = !wr; x.data = exp_rd; x.cyc = cyc_cnt + 1 + ws_of(d);
    sb_q[d].push_back(x);
    @(negedge clk);
    adr_i[d] = ~a; wd_i[d] = ~wd; we_i[d] = ~wr;
    repeat (ws_of(d)) @(negedge clk);
    cyc_i[d] = 1'b0; stb_i[d] = 1'b0;
  endtask

  // Monitor: every ack must match the oldest expectation; rdData must be 0 otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (ack_o[d] === 1'b1) begin
          chk($sformatf("ack_width%0d", d), 32'(prev_ack[d]), 32'd0);
          if (sb_q[d].size() == 0) begin
            chk($sformatf("unexpected_ack%0d", d), 32'd1, 32'd0);
          end else begin
            e = sb_q[d].pop_front();
            chk($sformatf("ack_cycle%0d", d), cyc_cnt, e.cyc);
            if (e.is_rd) chk($sformatf("rd_data%0d", d), 32'(rd_o[d]), 32'(e.data));
          end
        end else begin
          chk($sformatf("rd_idle%0d", d), 32'(rd_o[d]), 32'd0);
        end
        prev_ack[d] = ack_o[d];
      end
    end
  end

  initial begin
    exp_t x;
    rst = 1'b0;
    status = 16'h55AA;
    for (int d = 0; d < 2; d++) begin
      cyc_i[d] = 1'b0; stb_i[d] = 1'b0; we_i[d] = 1'b0;
      adr_i[d] = 4'h0; wd_i[d] = 16'h0; prev_ack[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ack%0d", d), 32'(ack_o[d]), 32'd0);
      chk($sformatf("rst_rd%0d", d), 32'(rd_o[d]), 32'd0);
      chk($sformatf("rst_ctrl%0d", d), 32'(ctrl_o[d]), 32'd0);
    end
    rst = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) xfer(0, 1'b0, 4'(i), 16'h0, 16'h0000);
    xfer(0, 1'b0, 4'hF, 16'h0, 16'h55AA);

    // Zero wait states write/read
    xfer(0, 1'b1, 4'h3, 16'hBEEF, 16'h0);
    xfer(0, 1'b0, 4'h3, 16'h0, 16'hBEEF);

    // Three wait states, register 0 drives ctrl_out
    xfer(1, 1'b0, 4'h0, 16'h0, 16'h0000);
    xfer(1, 1'b1, 4'h0, 16'h00A5, 16'h0);
    chk("ctrl_out_u3", 32'(ctrl_o[1]), 32'h00A5);
    chk("ctrl_out_u0", 32'(ctrl_o[0]), 32'h0000);
    xfer(1, 1'b0, 4'h0, 16'h0, 16'h00A5);

    // Status word is read-only
    xfer(0, 1'b0, 4'hF, 16'h0, 16'h55AA);
    xfer(0, 1'b1, 4'hF, 16'hFFFF, 16'h0);
    status = 16'h1234;
    xfer(0, 1'b0, 4'hF, 16'h0, 16'h1234);
    status = 16'h55AA;
    xfer(1, 1'b0, 4'hF, 16'h0, 16'h55AA);

    // Abort during wait states
    @(negedge clk);
    cyc_i[1] = 1'b1; stb_i[1] = 1'b1; we_i[1] = 1'b1; adr_i[1] = 4'h5; wd_i[1] = 16'h1234;
    @(negedge clk);
    stb_i[1] = 1'b0; cyc_i[1] = 1'b0;
    repeat (5) @(negedge clk);
    xfer(1, 1'b0, 4'h5, 16'h0, 16'h0000);

    // Back-to-back writes with strobe held
    @(negedge clk);
    cyc_i[0] = 1'b1; stb_i[0] = 1'b1; we_i[0] = 1'b1; adr_i[0] = 4'h1; wd_i[0] = 16'h1111;
    x.is_rd = 1'b0; x.data = 16'h0; x.cyc = cyc_cnt + 1;
    sb_q[0].push_back(x);
    @(negedge clk);
    adr_i[0] = 4'h2; wd_i[0] = 16'h2222;
    x.cyc = cyc_cnt + 2;
    sb_q[0].push_back(x);
    repeat (2) @(negedge clk);
    cyc_i[0] = 1'b0; stb_i[0] = 1'b0;
    xfer(0, 1'b0, 4'h1, 16'h0, 16'h1111);
    xfer(0, 1'b0, 4'h2, 16'h0, 16'h2222);
    xfer(0, 1'b0, 4'h3, 16'h0, 16'hBEEF);

    // Reset during WAIT of a write
    @(negedge clk);
    cyc_i[1] = 1'b1; stb_i[1] = 1'b1; we_i[1] = 1'b1; adr_i[1] = 4'h6; wd_i[1] = 16'h7777;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cyc_i[1] = 1'b0; stb_i[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("ctrl_after_rst", 32'(ctrl_o[1]), 32'h0000);
    xfer(1, 1'b0, 4'h6, 16'h0, 16'h0000);
    xfer(0, 1'b0, 4'h3, 16'h0, 16'h0000);

    repeat (6) @(negedge clk);
    chk("pending0", 32'(sb_q[0].size()), 32'd0);
    chk("pending1", 32'(sb_q[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
